// File: rtl/parity_frame_tx.sv
// Purpose: serialises one DATA_W-bit word per handshake as start(0), data LSB-first, parity, stop(1)s.
// Latency: the start bit begins the cycle after accept; a frame is (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: data_ready is high only in IDLE; valid while busy is ignored and the word is not queued.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              parity_odd_sel,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              frame_done
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + STOP_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                tx_serial_q, tx_serial_d;
    logic                frame_done_q, frame_done_d;
    logic                last_tick;

    assign last_tick  = (tick_q == TICK_LAST);
    assign data_ready = (state_q == S_IDLE);
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_serial  = tx_serial_q;
    assign frame_done = frame_done_q;

    // Next-state: advance tick/bit counters, shift data at bit boundaries, and
    // pre-compute the line level and done pulse for the following cycle.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        tx_serial_d  = 1'b1;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (data_valid) begin
                    shreg_d = data_in;
                    par_d   = (^data_in) ^ parity_odd_sel;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_tick) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    tick_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    tick_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level for the next cycle follows the state being entered, so the
        // output register changes exactly at bit boundaries.
        case (state_d)
            S_START:  tx_serial_d = 1'b0;
            S_DATA:   tx_serial_d = shreg_d[0];
            S_PARITY: tx_serial_d = par_d;
            default:  tx_serial_d = 1'b1;
        endcase

        frame_done_d = (state_d == S_STOP) && (tick_d == TICK_LAST) && (bit_d == STOP_LAST);
    end

    // State and output registers; reset forces an idle, high line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tx_serial_q  <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tx_serial_q  <= tx_serial_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Purpose: scoreboard bench for parity_frame_tx with a UART-style receiver model.
// Latency: expects the start bit the cycle after accept and frame_done on the last stop cycle.
// Backpressure: drives valid only into data_ready; mid-frame valid pulses must be ignored.
module tb_parity_frame_tx;
    localparam int C    = 4;
    localparam int W    = 8;
    localparam int SB   = 1;
    localparam int NB   = 2 + W + SB;
    localparam int FLEN = NB * C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         parity_odd_sel = 1'b0;
    logic         data_ready, tx_serial, tx_busy, frame_done;

    parity_frame_tx #(.CLKS_PER_BIT(C), .DATA_W(W), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .parity_odd_sel(parity_odd_sel),
        .tx_serial(tx_serial), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0, cyc = 0, fd_count = 0, pushed = 0, frames_rx = 0;
    logic mon_en = 1'b1, mon_busy = 1'b0;
    logic [W:0] exp_q[$];      // {odd_sel, data}
    int         start_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Receiver model: captures a whole frame from its first start cycle, samples each bit mid-way.
    initial begin : monitor
        logic         line [FLEN];
        logic         fdv  [FLEN];
        logic         bsy  [FLEN];
        logic [W-1:0] rx_d;
        logic         rx_par, stable, fd_ok, busy_ok, stop_ok;
        logic [W:0]   e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx_serial === 1'b0) begin
                mon_busy = 1'b1;
                start_cyc.push_back(cyc);
                line[0] = tx_serial; fdv[0] = frame_done; bsy[0] = tx_busy;
                for (int i = 1; i < FLEN; i++) begin
                    @(negedge clk);
                    line[i] = tx_serial; fdv[i] = frame_done; bsy[i] = tx_busy;
                end
                stable = 1'b1; fd_ok = 1'b1; busy_ok = 1'b1; stop_ok = 1'b1;
                for (int b = 0; b < NB; b++)
                    for (int s = 0; s < C; s++)
                        if (line[b*C+s] !== line[b*C]) stable = 1'b0;
                for (int i = 0; i < FLEN; i++) begin
                    if (fdv[i] !== (i == FLEN - 1)) fd_ok = 1'b0;
                    if (bsy[i] !== 1'b1) busy_ok = 1'b0;
                end
                for (int k = 0; k < W; k++) rx_d[k] = line[(1 + k) * C + C / 2];
                rx_par = line[(1 + W) * C + C / 2];
                for (int s = 0; s < SB; s++)
                    if (line[(2 + W + s) * C + C / 2] !== 1'b1) stop_ok = 1'b0;
                check("bit_stable", stable, 1);
                check("frame_done_timing", fd_ok, 1);
                check("busy_in_frame", busy_ok, 1);
                check("stop_bits", stop_ok, 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got frame %0h expected none", rx_d);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", rx_d, e[W-1:0]);
                    // even: ones in data+parity even; odd: ones in data+parity odd
                    check("rx_parity", rx_par, ($countones(e[W-1:0]) % 2) ^ int'(e[W]));
                end
                frames_rx++;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic odd, input bit push, input bit keep);
        int guard;
        guard = 0;
        @(negedge clk);
        data_in = d; parity_odd_sel = odd; data_valid = 1'b1;
        while (data_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got data_ready=%0b expected 1", data_ready);
            data_valid = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back({odd, d});
            pushed++;
        end
        @(posedge clk); #1;
        if (!keep) data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy || tx_busy) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int fdc, fd0, n;
        // Reset values while rst is held
        #12;
        check("rst_tx_serial", tx_serial, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_data_ready", data_ready, 1);
        check("rst_frame_done", frame_done, 0);
        @(negedge clk); rst = 1'b0;

        // Directed words and parity cases
        send(8'hA5, 1'b0, 1, 0);
        send(8'h07, 1'b1, 1, 0);
        send(8'h07, 1'b0, 1, 0);
        send(8'h00, 1'b1, 1, 0);
        send(8'hFF, 1'b0, 1, 0);
        wait_drain();

        // Back-to-back with valid held high: period is one frame plus one idle cycle
        send(8'h3C, 1'b0, 1, 1);
        send(8'hC3, 1'b1, 1, 0);
        wait_drain();
        n = start_cyc.size();
        check("b2b_period", start_cyc[n-1] - start_cyc[n-2], FLEN + 1);

        // Mid-frame input churn must not disturb the latched word
        send(8'h96, 1'b1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data_in = W'($urandom);
            parity_odd_sel = 1'($urandom);
            data_valid = (i % 3 == 0);
            #1;
            if (i % 5 == 0) check("busy_not_ready", data_ready, 0);
        end
        @(negedge clk); data_valid = 1'b0;
        wait_drain();

        // Reset during data bit 3 (bit 3 of 0x52 is 0)
        mon_en = 1'b0;
        send(8'h52, 1'b0, 0, 0);
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_busy", tx_busy, 1);
        check("pre_rst_line", tx_serial, 0);
        fdc = fd_count;
        rst = 1'b1;
        #1;
        check("midrst_tx_serial", tx_serial, 1);
        check("midrst_tx_busy", tx_busy, 0);
        check("midrst_data_ready", data_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_no_frame_done", fd_count - fdc, 0);
        check("midrst_no_resume", tx_busy, 0);
        mon_en = 1'b1;
        send(8'h3B, 1'b1, 1, 0);
        wait_drain();

        // Random words, random parity selection, random valid gaps
        fd0 = fd_count;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(W'($urandom), 1'($urandom), 1, 0);
        end
        wait_drain();
        check("random_frame_done_count", fd_count - fd0, 200);

        check("frames_rx_total", frames_rx, pushed);
        check("frame_done_total", fd_count, pushed);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
